// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding imem read,
// IF/ID register with a one-entry skid buffer for decode stalls.
module fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [5:0]         opcode_out,
  output logic               valid_out,
  output logic [31:0]        fetch_count
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  pc_reg, pc_d;
  logic [ADDR_W-1:0]  drain_addr, drain_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pcq_d;
  logic               valid_q, valid_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [INSTR_W-1:0] skid_instr, skid_instr_d;
  logic [ADDR_W-1:0]  skid_pc, skid_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= START;
      pc_reg     <= RESET_PC;
      drain_addr <= '0;
      instr_q    <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      state      <= state_d;
      pc_reg     <= pc_d;
      drain_addr <= drain_d;
      instr_q    <= instr_d;
      pc_q       <= pcq_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      skid_instr <= skid_instr_d;
      skid_pc    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state;
    pc_d         = pc_reg;
    drain_d      = drain_addr;
    instr_d      = instr_q;
    pcq_d        = pc_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    skid_instr_d = skid_instr;
    skid_pc_d    = skid_pc;
    unique case (state)
      START: state_d = FETCH;
      FETCH: begin
        if (redirect) begin
          pc_d         = redirect_pc;
          valid_d      = 1'b0;
          skid_instr_d = '0;
          skid_pc_d    = '0;
          if (!imem_valid) begin
            state_d = DRAIN;
            drain_d = pc_reg;
          end
        end else if (imem_valid) begin
          pc_d = pc_reg + PC_STEP;
          if (stall && valid_q) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_reg;
            state_d      = HOLD;
          end else begin
            instr_d = imem_rdata;
            pcq_d   = pc_reg;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
          end
        end else if (!stall) begin
          // decode took the word and nothing new arrived: bubble
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d         = redirect_pc;
          valid_d      = 1'b0;
          skid_instr_d = '0;
          skid_pc_d    = '0;
          state_d      = FETCH;
        end else if (!stall) begin
          instr_d = skid_instr;
          pcq_d   = skid_pc;
          cnt_d   = cnt_q + 32'd1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end
        if (imem_valid) state_d = FETCH;
      end
    endcase
  end

  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = (state == DRAIN) ? drain_addr : pc_reg;
  assign instr_out   = instr_q;
  assign pc_out      = pc_q;
  assign opcode_out  = instr_q[INSTR_W-1:INSTR_W-6];
  assign valid_out   = valid_q;
  assign fetch_count = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Owns the PC and issues one-outstanding-request reads to instruction memory.
- Captures returned words into the IF/ID register and presents the 6-bit opcode field to decode.
- Handles decode stalls and branch/jump redirects from execute (pc_src path), and discards stale in-flight responses.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- INSTR_W, 32, instruction width; opcode is bits [INSTR_W-1:INSTR_W-6].
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request; held with imem_addr stable until imem_valid.
- imem_addr  out  ADDR_W  fetch address (equals pc_reg while requesting).
- imem_rdata  in  INSTR_W  returned instruction word.
- imem_valid  in  1  response strobe; completes the outstanding request this cycle.
- stall  in  1  decode cannot accept; IF/ID register holds.
- redirect  in  1  taken branch/jump from execute.
- redirect_pc  in  ADDR_W  target address, valid with redirect.
- instr_out  out  INSTR_W  IF/ID instruction.
- pc_out  out  ADDR_W  IF/ID PC of instr_out.
- opcode_out  out  6  instr_out[INSTR_W-1:INSTR_W-6], feeds control unit opcode.
- valid_out  out  1  IF/ID holds a live instruction.
- fetch_count  out  32  number of instructions delivered to IF/ID (wraps).

Behaviour:
- Reset (rst=1 at an edge), taking priority over all other inputs:
  - state=START, pc_reg=RESET_PC, imem_req=0, valid_out=0.
  - instr_out=0, pc_out=0, fetch_count=0, skid buffer empty.
- Priority per cycle: rst > redirect > stall > normal fetch.
- States:
  - START: imem_req=0 for one cycle after reset, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc_reg. On imem_valid:
    - If stall=0: IF/ID<=word/pc_reg, valid_out<=1, fetch_count+=1, pc_reg+=PC_STEP; stay FETCH.
    - If stall=1 and valid_out=1: word/pc go to the skid buffer, pc_reg+=PC_STEP, go HOLD.
    - If stall=1 and valid_out=0: load IF/ID directly; no HOLD.
  - HOLD: imem_req=0. When stall=0: IF/ID<=skid buffer, fetch_count+=1, go FETCH.
  - DRAIN: imem_req=1 with the old address held stable. On imem_valid: discard the word, go FETCH at pc_reg (already the target).
- Without imem_valid, FETCH holds imem_req and imem_addr; stall alone never drops a request in flight.
- Fetch latency: minimum one cycle from request to IF/ID when memory answers in the same cycle. Throughput is one instruction per cycle when stall=0.
- Redirect (any state except START):
  - pc_reg<=redirect_pc, valid_out<=0 next cycle, skid buffer cleared.
  - FETCH with no imem_valid this cycle: go DRAIN.
  - FETCH with imem_valid the same cycle: discard the word, stay FETCH at the target; no DRAIN.
  - HOLD: go FETCH.
  - DRAIN: stays DRAIN with the target updated.
  - Redirect overrides stall.
- Stall with valid_out=1: instr_out, pc_out, opcode_out and valid_out are bit-stable.
- PC arithmetic is modulo 2^ADDR_W; wrap at the top of the address space is silent.
- fetch_count wraps 2^32-1 -> 0.
- opcode_out is combinational from instr_out; no extra latency.
- rst mid-DRAIN or mid-HOLD abandons the response. The bench's memory model must tolerate a dropped request.

Test Plan:
- Reset then zero-latency memory returning addr-tagged words, stall=0 -> imem_addr 0,4,8,…; pc_out 0,4,8 on consecutive cycles; valid_out=1 from cycle 2; fetch_count=3 after 3 words.
- Word 0x04000000 at addr 0 -> opcode_out=6'b000001 (ADD) one cycle after imem_valid.
- Word 0x24000000 at addr 0 -> opcode_out=6'b001001 (ADDI) one cycle after imem_valid.
- stall=1 for 3 cycles while word @8 arrives -> IF/ID keeps pc_out=4 throughout; state HOLD, imem_req=0. On release, pc_out=8 next cycle, then the fetch at 12.
- Memory latency 3, redirect to 0x100 one cycle after the request @8 issued -> imem_addr stays 8 until valid; that word is never visible; valid_out=0; next request addr 0x100; pc_out=0x100 on delivery.
- redirect and imem_valid in the same cycle, redirect_pc=0x40 -> no DRAIN; next imem_addr=0x40; the returned word is dropped and fetch_count unchanged.
- rst asserted during DRAIN and HOLD -> next cycle all outputs at reset values; first request addr=RESET_PC after START.
- pc_reg=0xFFFFFFFC with PC_STEP=4 -> next fetch address 0x00000000.
